mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Parametrised successor to the single-cycle MEM stage. Sits between the EX/MEM and MEM/WB pipeline registers.
- Performs byte, halfword, word (and doubleword when XLEN=64) loads and stores, with byte enables and sign/zero extension.
- Talks to a variable-latency data memory over a req/gnt/rvalid handshake and stalls upstream while an access is outstanding.
- Flags misaligned accesses instead of performing them.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
ADDR_WIDTH, 12, byte-address bits presented to data memory.
NB, XLEN/8, byte lanes (derived; not overridable).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  EX/MEM entry valid
in_alu_result  in  XLEN  effective address / ALU result
in_rs2_data  in  XLEN  store data
in_rd  in  5  destination register
in_funct3  in  3  RISC-V load/store width code
in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg  in  1 each  control
stall  out  1  hold EX/MEM and earlier stages
dmem_req  out  1  access request
dmem_we  out  1  write enable
dmem_addr  out  ADDR_WIDTH-log2(NB)  word address = in_alu_result[ADDR_WIDTH-1:log2(NB)]
dmem_be  out  NB  byte enables
dmem_wdata  out  XLEN  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  XLEN  read data
wb_valid, wb_reg_write, wb_mem_to_reg, wb_misaligned  out  1 each  MEM/WB control
wb_rd  out  5;  wb_alu_result, wb_mem_data  out  XLEN  MEM/WB data

Behaviour:
- Reset (reset_n low, async): FSM returns to IDLE; all wb_* outputs become 0. stall, dmem_req, dmem_we, dmem_be and dmem_wdata are 0 while in reset.
- memop = in_valid & (in_mem_read | in_mem_write).
- mis = memop & address not aligned to the access size.
- Unsupported funct3: treated as misaligned.
- FSM states: IDLE and WAIT_R.
- IDLE:
  - dmem_req = memop & !mis (combinational).
  - dmem_we = in_mem_write.
  - Store with gnt: completes this cycle; stall=0; MEM/WB captures at the edge.
  - Load with gnt: go to WAIT_R; stall=1.
  - No gnt: stay in IDLE; stall=1. Upstream holds inputs stable while stall=1.
- WAIT_R:
  - dmem_req=0; stall=1 until dmem_rvalid.
  - On rvalid: stall=0; capture extended data into wb_mem_data; go to IDLE.
  - rvalid is never sampled in the gnt cycle, so minimum latency is load 2 cycles, store 1 cycle.
- dmem_rvalid in IDLE is ignored. Reset during WAIT_R drops the transaction; a late rvalid after reset is ignored.
- Non-memory ops and misaligned ops: no request; stall=0; 1-cycle pass-through.
- Misaligned op: wb_misaligned=1 and wb_reg_write forced to 0.
- While stall=1: MEM/WB is loaded with a bubble (wb_valid=0, wb_reg_write=0).
- Otherwise wb_* <= in_* each cycle; wb_mem_data updates only on load completion.
- Load extension (offset = addr[log2(NB)-1:0]):
  - LB/LBU: byte at lane offset, sign- or zero-extended to XLEN.
  - LH/LHU: halfword at lanes offset..offset+1, sign- or zero-extended to XLEN.
  - LW: word; sign-extended when XLEN=64.
  - LWU/LD: only when XLEN=64.
- Stores:
  - dmem_be is one contiguous run of 1/2/4/8 bits starting at offset.
  - dmem_wdata replicates the byte/half/word across all lanes.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU; stores SB/SH/SW/SD);
  - the FSM state enum;
  - a mem_wb_ext_t struct parametrised via XLEN-sized fields.
- Sub-module lsu_align (combinational): funct3 + offset + rs2/rdata -> be, wdata, extended load data, mis.
- The top module holds the FSM and the MEM/WB register.

Test Plan:
- Reset mid-load: assert reset_n=0 during WAIT_R, release, then pulse rvalid -> wb_* stay 0; state is IDLE; no spurious wb_valid.
- SB, addr 0x103, rs2=0x000000AB, gnt same cycle -> dmem_be=4'b1000, dmem_wdata=0xABABABAB, stall=0, wb_valid=1 next edge.
- LB, addr 0x101, gnt delayed 2 cycles, rvalid 3 cycles later with rdata=0x1234F600 -> stall high 5 cycles, wb_mem_data=0xFFFFFFF6. Repeat as LBU -> 0x000000F6.
- LH, addr 0x102, rdata=0x8001_7777 -> be=4'b1100, wb_mem_data=0xFFFF8001. LH at 0x101 -> no dmem_req, wb_misaligned=1, wb_reg_write=0, stall=0.
- ALU op (in_reg_write=1, no memop) back-to-back with a stalled store -> ALU result appears in the cycle after the store completes; bubbles have wb_valid=0.
- XLEN=64 build: SD addr 0x8 -> be=8'hFF. LWU addr 0xC, rdata upper word 0x80000001 -> wb_mem_data=0x0000000080000001. LW of the same word -> 0xFFFFFFFF80000001.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: width codes, FSM state, MEM/WB bundle.
// Fields are sized for the widest supported datapath.
package lsu_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic {
    S_IDLE,
    S_WAIT_R
  } lsu_state_e;

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                mem_to_reg;
    logic                misaligned;
    logic [4:0]          rd;
    logic [XLEN_MAX-1:0] alu_result;
    logic [XLEN_MAX-1:0] mem_data;
  } mem_wb_ext_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables, store replication, load extension and
// misalignment / unsupported-width detection.
import lsu_pkg::*;

module lsu_align #(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OW   = $clog2(NB)
) (
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [OW-1:0]   offset,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ldata,
  output logic            mis
);

  logic [1:0]      sz;
  logic [NB-1:0]   run;
  logic [XLEN-1:0] sh;
  logic            unsup;

  assign sz = funct3[1:0];

  always_comb begin
    run = '0;
    for (int i = 0; i < NB; i++)
      run[i] = (i < (1 << sz));
  end

  assign be = run << offset;

  // every lane carries the low byte/half/word of rs2
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NB; i++)
      wdata[8*i +: 8] = rs2[8*(i % (1 << sz)) +: 8];
  end

  always_comb begin
    if (is_store)
      unsup = funct3[2] || (XLEN == 32 && funct3 == F3_SD);
    else
      unsup = (funct3 == 3'b111) ||
              (XLEN == 32 && (funct3 == F3_LD || funct3 == F3_LWU));
  end

  assign mis = unsup ||
    ((32'(offset) & ((32'd1 << sz) - 32'd1)) != 32'd0);

  assign sh = rdata >> (8 * offset);

  always_comb begin
    case (funct3)
      F3_LB:   ldata = XLEN'($signed(sh[7:0]));
      F3_LH:   ldata = XLEN'($signed(sh[15:0]));
      F3_LW:   ldata = XLEN'($signed(sh[31:0]));
      F3_LBU:  ldata = XLEN'(sh[7:0]);
      F3_LHU:  ldata = XLEN'(sh[15:0]);
      F3_LWU:  ldata = XLEN'(sh[31:0]);
      default: ldata = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: req/gnt/rvalid data-memory FSM and the MEM/WB register.
// Stalls upstream while an access is outstanding.
import lsu_pkg::*;

module mem_stage_lsu #(
  parameter  int XLEN       = 32,
  parameter  int ADDR_WIDTH = 12,
  localparam int NB         = XLEN / 8,
  localparam int OW         = $clog2(NB)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_alu_result,
  input  logic [XLEN-1:0]          in_rs2_data,
  input  logic [4:0]               in_rd,
  input  logic [2:0]               in_funct3,
  input  logic                     in_mem_read,
  input  logic                     in_mem_write,
  input  logic                     in_reg_write,
  input  logic                     in_mem_to_reg,
  output logic                     stall,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDR_WIDTH-OW-1:0] dmem_addr,
  output logic [NB-1:0]            dmem_be,
  output logic [XLEN-1:0]          dmem_wdata,
  input  logic                     dmem_gnt,
  input  logic                     dmem_rvalid,
  input  logic [XLEN-1:0]          dmem_rdata,
  output logic                     wb_valid,
  output logic                     wb_reg_write,
  output logic                     wb_mem_to_reg,
  output logic                     wb_misaligned,
  output logic [4:0]               wb_rd,
  output logic [XLEN-1:0]          wb_alu_result,
  output logic [XLEN-1:0]          wb_mem_data
);

  lsu_state_e      state, state_nx;
  mem_wb_ext_t     wb_q;
  logic            memop, mis, mis_a;
  logic            req_c, stall_c, done_ld;
  logic [NB-1:0]   be_a;
  logic [XLEN-1:0] wdata_a, ldata_a;

  assign memop = in_valid & (in_mem_read | in_mem_write);
  assign mis   = memop & mis_a;

  lsu_align #(.XLEN(XLEN)) u_align (
    .is_store (in_mem_write),
    .funct3   (in_funct3),
    .offset   (in_alu_result[OW-1:0]),
    .rs2      (in_rs2_data),
    .rdata    (dmem_rdata),
    .be       (be_a),
    .wdata    (wdata_a),
    .ldata    (ldata_a),
    .mis      (mis_a)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req_c    = 1'b0;
    stall_c  = 1'b0;
    done_ld  = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_c = memop & ~mis;
        if (req_c) begin
          if (!dmem_gnt) begin
            stall_c = 1'b1;
          end else if (!in_mem_write) begin
            stall_c  = 1'b1;
            state_nx = S_WAIT_R;
          end
        end
      end
      S_WAIT_R: begin
        stall_c = ~dmem_rvalid;
        if (dmem_rvalid) begin
          done_ld  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // memory-side outputs stay quiet while reset is held
  assign stall      = reset_n & stall_c;
  assign dmem_req   = reset_n & req_c;
  assign dmem_we    = dmem_req & in_mem_write;
  assign dmem_be    = dmem_req ? be_a : '0;
  assign dmem_wdata = dmem_req ? wdata_a : '0;
  assign dmem_addr  = in_alu_result[ADDR_WIDTH-1:OW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_q <= '0;
    end else begin
      wb_q.valid      <= in_valid & ~stall_c;
      wb_q.reg_write  <= in_reg_write & ~mis & ~stall_c;
      wb_q.mem_to_reg <= in_mem_to_reg;
      wb_q.misaligned <= mis;
      wb_q.rd         <= in_rd;
      wb_q.alu_result <= XLEN_MAX'(in_alu_result);
      if (done_ld)
        wb_q.mem_data <= XLEN_MAX'(ldata_a);
    end
  end

  assign wb_valid      = wb_q.valid;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_misaligned = wb_q.misaligned;
  assign wb_rd         = wb_q.rd;
  assign wb_alu_result = wb_q.alu_result[XLEN-1:0];
  assign wb_mem_data   = wb_q.mem_data[XLEN-1:0];

  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{wb_q.alu_result[XLEN_MAX-1:XLEN],
                         wb_q.mem_data[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu (32-bit instance) plus a few
// directed checks on a 64-bit instance.
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_mem_read, in_mem_write;
  logic        in_reg_write, in_mem_to_reg;
  logic [31:0] in_alu_result, in_rs2_data;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic        stall, dmem_req, dmem_we;
  logic [9:0]  dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_gnt, dmem_rvalid;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg, wb_misaligned;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_result, wb_mem_data;

  logic        v64, stall64, req64, we64, gnt64, rv64;
  logic [63:0] alu64, rs2_64, wdata64, rdata64;
  logic [8:0]  addr64;
  logic [7:0]  be64;
  logic        wbv64, wbrw64, wbm2r64, wbmis64;
  logic [4:0]  wbrd64;
  logic [63:0] wbalu64, wbmem64;

  mem_stage_lsu dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .in_alu_result(in_alu_result), .in_rs2_data(in_rs2_data),
    .in_rd(in_rd), .in_funct3(in_funct3),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_misaligned(wb_misaligned),
    .wb_rd(wb_rd), .wb_alu_result(wb_alu_result),
    .wb_mem_data(wb_mem_data)
  );

  mem_stage_lsu #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(v64),
    .in_alu_result(alu64), .in_rs2_data(rs2_64),
    .in_rd(in_rd), .in_funct3(in_funct3),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .stall(stall64), .dmem_req(req64), .dmem_we(we64),
    .dmem_addr(addr64), .dmem_be(be64),
    .dmem_wdata(wdata64), .dmem_gnt(gnt64),
    .dmem_rvalid(rv64), .dmem_rdata(rdata64),
    .wb_valid(wbv64), .wb_reg_write(wbrw64),
    .wb_mem_to_reg(wbm2r64), .wb_misaligned(wbmis64),
    .wb_rd(wbrd64), .wb_alu_result(wbalu64),
    .wb_mem_data(wbmem64)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        chk_mem;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always @(negedge clk) begin
    if (reset_n) begin
      if (wb_valid) begin
        if (q.size() == 0) begin
          chk("spurious_wb", 1, 0);
        end else begin
          e = q.pop_front();
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_reg_write", wb_reg_write, e.rw);
          chk("wb_misaligned", wb_misaligned, e.mis);
          chk("wb_alu", wb_alu_result, e.alu);
          if (e.chk_mem) chk("wb_mem", wb_mem_data, e.mem);
        end
      end else begin
        chk("bubble_rw", wb_reg_write, 0);
      end
    end
  end

  task automatic idle();
    in_valid = 0; in_mem_read = 0; in_mem_write = 0;
    in_reg_write = 0; in_mem_to_reg = 0;
    dmem_gnt = 0; dmem_rvalid = 0;
  endtask

  task automatic do_op(input string nm, input logic rd_, wr_, rw_,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, rdat, input logic [4:0] rd,
                       input int gd, rv, input logic ereq,
                       input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic emis, input logic [31:0] emem,
                       input int est);
    int c, st;
    logic s;
    exp_t x;
    in_valid = 1; in_mem_read = rd_; in_mem_write = wr_;
    in_reg_write = rw_; in_mem_to_reg = rd_; in_funct3 = f3;
    in_alu_result = addr; in_rs2_data = rs2; in_rd = rd;
    x.rd = rd; x.rw = rw_ & ~emis; x.mis = emis; x.alu = addr;
    x.mem = emem; x.chk_mem = rd_ & ~emis;
    q.push_back(x);
    c = 0; st = 0;
    forever begin
      dmem_gnt = (c == gd);
      dmem_rvalid = rd_ && (c == gd + rv);
      dmem_rdata = rdat;
      #1;
      if (c == 0) chk({nm, "_req"}, dmem_req, ereq);
      if (ereq && c == gd) begin
        chk({nm, "_be"}, dmem_be, ebe);
        chk({nm, "_we"}, dmem_we, wr_);
        if (wr_) chk({nm, "_wdata"}, dmem_wdata, ewd);
      end
      if (ereq && c > gd) chk({nm, "_req_wait"}, dmem_req, 0);
      s = stall;
      @(posedge clk); #1;
      if (!s) break;
      st++; c++;
      if (c > 40) begin
        chk({nm, "_timeout"}, 1, 0);
        break;
      end
    end
    chk({nm, "_stall_cycles"}, st, est);
  endtask

  task automatic do64(input string nm, input logic ld,
                      input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] rs2, rdat,
                      input logic [7:0] ebe, input logic [63:0] ewd,
                      input logic [63:0] emem);
    v64 = 1; in_mem_read = ld; in_mem_write = ~ld;
    in_mem_to_reg = ld; in_reg_write = 0; in_funct3 = f3;
    alu64 = addr; rs2_64 = rs2; rdata64 = rdat; gnt64 = 1; rv64 = 0;
    #1;
    chk({nm, "_req"}, req64, 1);
    chk({nm, "_be"}, be64, ebe);
    chk({nm, "_addr"}, addr64, 64'(addr[11:3]));
    if (!ld) begin
      chk({nm, "_wdata"}, wdata64, ewd);
      chk({nm, "_stall"}, stall64, 0);
    end
    @(posedge clk); #1;
    gnt64 = 0;
    if (ld) begin
      chk({nm, "_wait_stall"}, stall64, 1);
      rv64 = 1; #1;
      chk({nm, "_rv_stall"}, stall64, 0);
      @(posedge clk); #1;
      rv64 = 0;
      chk({nm, "_mem"}, wbmem64, emem);
    end
    chk({nm, "_wbv"}, wbv64, 1);
    v64 = 0; in_mem_read = 0; in_mem_write = 0; in_mem_to_reg = 0;
  endtask

  initial begin
    v64 = 0; alu64 = '0; rs2_64 = '0; rdata64 = '0;
    gnt64 = 0; rv64 = 0;
    idle();
    in_alu_result = 32'h100; in_rs2_data = 32'hFF;
    in_rd = 5'd1; in_funct3 = 3'd2; dmem_rdata = '0;
    in_valid = 1; in_mem_write = 1; in_reg_write = 1;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wbrw", wb_reg_write, 0);
    chk("rst_wbrd", wb_rd, 0);
    chk("rst_wbalu", wb_alu_result, 0);
    chk("rst_wbmem", wb_mem_data, 0);
    chk("rst_wbmis", wb_misaligned, 0);
    idle();
    #19 reset_n = 1;
    @(posedge clk); #1;

    do_op("sb", 0,1,0, 3'd0, 32'h103, 32'hAB, 0, 5'd0,
          0,1, 1, 4'b1000, 32'hABABABAB, 0, 0, 0);
    do_op("lb", 1,0,1, 3'd0, 32'h101, 0, 32'h1234F600, 5'd3,
          2,3, 1, 4'b0010, 0, 0, 32'hFFFFFFF6, 5);
    do_op("lbu", 1,0,1, 3'd4, 32'h101, 0, 32'h1234F600, 5'd4,
          2,3, 1, 4'b0010, 0, 0, 32'h000000F6, 5);
    do_op("lh", 1,0,1, 3'd1, 32'h102, 0, 32'h80017777, 5'd5,
          0,1, 1, 4'b1100, 0, 0, 32'hFFFF8001, 1);
    do_op("lh_mis", 1,0,1, 3'd1, 32'h101, 0, 0, 5'd6,
          0,1, 0, 0, 0, 1, 0, 0);
    do_op("sw", 0,1,0, 3'd2, 32'h200, 32'hDEADBEEF, 0, 5'd0,
          2,1, 1, 4'hF, 32'hDEADBEEF, 0, 0, 2);
    do_op("alu", 0,0,1, 3'd0, 32'h55, 0, 0, 5'd7,
          0,1, 0, 0, 0, 0, 0, 0);
    do_op("sh", 0,1,0, 3'd1, 32'h106, 32'h1234ABCD, 0, 5'd0,
          1,1, 1, 4'b1100, 32'hABCDABCD, 0, 0, 1);
    do_op("lw", 1,0,1, 3'd2, 32'h104, 0, 32'hCAFEF00D, 5'd8,
          0,2, 1, 4'hF, 0, 0, 32'hCAFEF00D, 2);
    do_op("lhu", 1,0,1, 3'd5, 32'h100, 0, 32'h00009ABC, 5'd9,
          1,1, 1, 4'b0011, 0, 0, 32'h00009ABC, 2);
    do_op("sw_mis", 0,1,0, 3'd2, 32'h202, 32'h1, 0, 5'd0,
          0,1, 0, 0, 0, 1, 0, 0);
    do_op("ld_xlen32", 1,0,1, 3'd3, 32'h100, 0, 0, 5'd12,
          0,1, 0, 0, 0, 1, 0, 0);
    do_op("st_bad_f3", 0,1,0, 3'd4, 32'h100, 0, 0, 5'd0,
          0,1, 0, 0, 0, 1, 0, 0);
    do_op("alu2", 0,0,1, 3'd0, 32'h77, 0, 0, 5'd10,
          0,1, 0, 0, 0, 0, 0, 0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", q.size(), 0);

    in_valid = 1; in_mem_read = 1; in_reg_write = 1;
    in_mem_to_reg = 1; in_funct3 = 3'd2;
    in_alu_result = 32'h300; in_rd = 5'd11; dmem_gnt = 1;
    #1;
    chk("rst_ld_req", dmem_req, 1);
    @(posedge clk); #1;
    dmem_gnt = 0;
    chk("rst_ld_wait_stall", stall, 1);
    reset_n = 0; #1;
    chk("rst_ld_stall", stall, 0);
    chk("rst_ld_req0", dmem_req, 0);
    chk("rst_ld_wbv", wb_valid, 0);
    idle();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1;
    dmem_rvalid = 1; dmem_rdata = 32'h5A5A5A5A; #1;
    chk("late_rv_stall", stall, 0);
    @(posedge clk); #1;
    dmem_rvalid = 0;
    chk("late_rv_wbv", wb_valid, 0);
    chk("late_rv_mem", wb_mem_data, 0);
    chk("late_rv_rw", wb_reg_write, 0);

    @(posedge clk); #1;
    do64("sd", 0, 3'd3, 64'h8, 64'h0123456789ABCDEF, 0,
         8'hFF, 64'h0123456789ABCDEF, 0);
    do64("lwu", 1, 3'd6, 64'hC, 0, 64'h80000001_00000000,
         8'hF0, 0, 64'h00000000_80000001);
    do64("lw64", 1, 3'd2, 64'hC, 0, 64'h80000001_00000000,
         8'hF0, 0, 64'hFFFFFFFF_80000001);
    do64("sb64", 0, 3'd0, 64'h15, 64'h5C, 0,
         8'h20, 64'h5C5C5C5C5C5C5C5C, 0);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
